mdu_sequencer: RTL and testbench

Multi-cycle multiply/divide unit with architectural HI/LO registers for the 32-bit MIPS core. It executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, beside the single-cycle ALU. It handshakes with the pipeline controller through start/busy/done so decode can stall MFHI/MFLO and new mul/div ops until the result is ready. It also services MTHI/MTLO writes.

---
 rtl/mdu_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative multiply/divide unit with architectural HI/LO registers.
//
// Executes MULTU/MULT/DIVU/DIV one bit per cycle. Latency from start sample to the
// done pulse is n+2 cycles. The unit also accepts MTHI/MTLO writes when not busy.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-high; clears all state
//   start          launch an operation (sampled only in IDLE or DONE)
//   op[1:0]        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b           multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we   MTHI/MTLO strobes, write wdata (dropped while busy)
//   wdata          MTHI/MTLO data
//   busy           operation in progress (RUN or FIX)
//   done           one-cycle pulse; hi/lo hold the new result
//   hi, lo         HI (product upper / remainder), LO (product lower / quotient)
//
// Build option: define MDU_EARLY_TERM_EN to let multiplies leave RUN as soon as
// the remaining multiplier bits are zero. Results are the same either way.

module mdu_sequencer #(
   parameter int n = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         hi_we,
   input  logic         lo_we,
   input  logic [n-1:0] wdata,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] hi,
   output logic [n-1:0] lo
);

   localparam int cw = $clog2(n + 1);

   typedef enum logic [1:0] {s_idle, s_run, s_fix, s_done} state_t;

   state_t state, state_nx;

   logic            op_div;     // latched op[1]
   logic            neg_q;      // negate quotient / product
   logic            neg_r;      // negate remainder (sign of dividend)
   logic            dz;         // divide by zero
   logic [cw-1:0]   cnt;

   // multiply work registers
   logic [2*n-1:0]  acc;
   logic [2*n-1:0]  mcand;
   logic [n-1:0]    mplier;

   // divide work registers
   logic [n-1:0]    rem;
   logic [n-1:0]    quo;
   logic [n-1:0]    dvsr;

   logic            take;
   logic            last;
   logic [n-1:0]    a_abs, b_abs;
   logic [n:0]      shifted;    // n+1-bit partial remainder
   logic [n+1:0]    diff;
   logic            unused_msb;
   logic [2*n-1:0]  prod;
   logic [n-1:0]    res_hi, res_lo;

   always_comb begin
      take  = start && (state == s_idle || state == s_done);
      a_abs = (op[0] && a[n-1]) ? -a : a;
      b_abs = (op[0] && b[n-1]) ? -b : b;
   end

   // RUN ends on its n-th cycle, or earlier for a multiply whose remaining
   // multiplier bits are all zero when early termination is built in.
   always_comb begin
      last = (cnt == cw'(1));
`ifdef MDU_EARLY_TERM_EN
      if (!op_div && mplier[n-1:1] == '0)
         last = 1'b1;
`endif
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= s_idle;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         s_idle: begin
            if (start)
               state_nx = s_run;
         end
         s_run: begin
            busy = 1'b1;
            if (last)
               state_nx = s_fix;
         end
         s_fix: begin
            busy     = 1'b1;
            state_nx = s_done;
         end
         s_done: begin
            done     = 1'b1;
            state_nx = start ? s_run : s_idle;
         end
         default: state_nx = s_idle;
      endcase
   end

   // ---------------- datapath ----------------
   // Restoring division: a negative diff (borrow in the top bit) means the
   // trial subtract failed, so the shifted remainder is kept unchanged. The
   // remainder is always below the divisor, so diff[n] is never needed.
   always_comb begin
      shifted    = {rem, quo[n-1]};
      diff       = {1'b0, shifted} - {2'b00, dvsr};
      unused_msb = diff[n];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         rem    <= '0;
         quo    <= '0;
         dvsr   <= '0;
      end else if (take) begin
         op_div <= op[1];
         neg_q  <= op[0] & (a[n-1] ^ b[n-1]);
         neg_r  <= op[0] & a[n-1];
         dz     <= op[1] & (b == '0);
         cnt    <= cw'(n);
         acc    <= '0;
         mcand  <= {{n{1'b0}}, a_abs};
         mplier <= b_abs;
         rem    <= '0;
         quo    <= a_abs;
         dvsr   <= b_abs;
      end else if (state == s_run) begin
         cnt <= cnt - 1'b1;
         if (op_div) begin
            quo <= {quo[n-2:0], ~diff[n+1]};
            rem <= diff[n+1] ? shifted[n-1:0] : diff[n-1:0];
         end else begin
            if (mplier[0])
               acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
         end
      end
   end

   // Sign fix-up. With a zero divisor the remainder path ends holding |a|,
   // so negating by the dividend sign restores the raw dividend for hi.
   always_comb begin
      prod   = neg_q ? -acc : acc;
      res_hi = prod[2*n-1:n];
      res_lo = prod[n-1:0];
      if (op_div) begin
         res_lo = dz ? '1 : (neg_q ? -quo : quo);
         res_hi = neg_r ? -rem : rem;
      end
   end

   // ---------------- HI/LO ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (state == s_fix) begin
         hi <= res_hi;
         lo <= res_lo;
      end else if (!busy) begin
         if (hi_we)
            hi <= wdata;
         if (lo_we)
            lo <= wdata;
      end
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench for mdu_sequencer.
// Stimulus pushes expected {start cycle, latency, hi, lo} per accepted start;
// a negedge monitor pops on done and checks latency, busy and the hi/lo values
// against a reference model built from 64-bit integer arithmetic.

module tb_mdu_sequencer;

   localparam int n = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    op    = 2'b00;
   logic [n-1:0]  a     = '0;
   logic [n-1:0]  b     = '0;
   logic          hi_we = 1'b0;
   logic          lo_we = 1'b0;
   logic [n-1:0]  wdata = '0;
   logic          busy, done;
   logic [n-1:0]  hi, lo;

   mdu_sequencer #(.n(n)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          k;
      int          l;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        sb[$];
   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic        pend_v = 1'b0, pend_h = 1'b0, pend_l = 1'b0;
   int          pend_cyc = 0;
   logic [31:0] pend_d = '0;
   int          free_at = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Reference model: plain 64-bit arithmetic on the architectural rules.
   function automatic void ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rh, output logic [31:0] rl, output int lat);
      longint      sx, sy, p, q, r;
      logic [63:0] w;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'b00: w = {32'b0, x} * {32'b0, y};
         2'b01: begin p = sx * sy; w = p; end
         2'b10: w = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
         default: begin
            if (y == 0) w = {x, 32'hFFFF_FFFF};
            else begin
               q = sx / sy;
               r = sx % sy;
               w = {r[31:0], q[31:0]};
            end
         end
      endcase
      rh  = w[63:32];
      rl  = w[31:0];
      lat = n + 2;
`ifdef MDU_EARLY_TERM_EN
      if (!o[1]) begin
         logic [31:0] mag;
         int          k;
         mag = (o[0] && y[31]) ? -y : y;
         k = 1;
         for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
         lat = k + 2;
      end
`endif
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clock) begin
      exp_t e;
      if (pend_v && cyc == pend_cyc) begin
         if (pend_h) m_hi = pend_d;
         if (pend_l) m_lo = pend_d;
         pend_v = 1'b0;
      end
      if (done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'(done), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("latency", 32'(cyc - e.k), 32'(e.l));
            m_hi = e.hi;
            m_lo = e.lo;
         end
      end else if (sb.size() > 0 && cyc >= sb[0].k + sb[0].l) begin
         chk("done_missing", 32'(done), 32'd1);
         e = sb.pop_front();
         m_hi = e.hi;
         m_lo = e.lo;
      end
      chk("busy", 32'(busy), 32'((sb.size() > 0 && cyc > sb[0].k) ? 1 : 0));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_free();
      while (cyc < free_at) tick();
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic hw, input logic lw, input logic [31:0] wd,
                        input logic fixed, input logic [31:0] fh, input logic [31:0] fl);
      exp_t        e;
      int          lat;
      logic [31:0] rh, rl;
      ref_op(o, x, y, rh, rl, lat);
      if (fixed) begin rh = fh; rl = fl; end
      e.k = cyc; e.l = lat; e.hi = rh; e.lo = rl;
      sb.push_back(e);
      if (hw || lw) begin
         pend_v = 1'b1; pend_h = hw; pend_l = lw; pend_d = wd; pend_cyc = cyc + 1;
      end
      free_at = cyc + lat;
      start = 1'b1; op = o; a = x; b = y; hi_we = hw; lo_we = lw; wdata = wd;
      tick();
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
   endtask

   task automatic poke_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      tick();
      start = 1'b0;
   endtask

   task automatic mt_write(input logic hw, input logic lw, input logic [31:0] wd, input logic accept);
      if (accept) begin
         pend_v = 1'b1; pend_h = hw; pend_l = lw; pend_d = wd; pend_cyc = cyc + 1;
      end
      hi_we = hw; lo_we = lw; wdata = wd;
      tick();
      hi_we = 1'b0; lo_we = 1'b0; wdata = $urandom;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      tick(); tick();
      reset = 1'b0;
      free_at = cyc;

      // MULTU max*max, with an ignored start and a dropped MTHI during RUN
      k0 = cyc;
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
      while (cyc < k0 + 10) tick();
      poke_start(2'b10, 32'd1, 32'd1);
      while (cyc < k0 + 12) tick();
      mt_write(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);

      // back-to-back start in DONE
      wait_free();
      issue(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

      // MTLO / MTHI while idle
      wait_free();
      tick(); tick();
      mt_write(1'b0, 1'b1, 32'h0000_1234, 1'b1);
      tick();
      mt_write(1'b1, 1'b1, 32'h0000_CAFE, 1'b1);
      tick();

      // divides, including MTHI alongside an accepted start
      issue(2'b10, 32'd100, 32'd7, 1'b1, 1'b0, 32'h5555_AAAA, 1'b1, 32'h0000_0002, 32'h0000_000E);
      wait_free();
      issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      wait_free();
      issue(2'b10, 32'd5, 32'd0, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0005, 32'hFFFF_FFFF);
      wait_free();
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0000, 32'h8000_0000);
      wait_free();
      issue(2'b11, 32'hFFFF_FFF6, 32'd0, 1'b0, 1'b0, '0, 1'b0, '0, '0);

`ifdef MDU_EARLY_TERM_EN
      wait_free();
      tick();
      issue(2'b00, 32'd7, 32'd3, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0000, 32'h0000_0015);
`endif

      // randomized operations with random gaps and occasional MTHI/MTLO
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  o;
         logic [31:0] x, y;
         logic        hw, lw;
         o  = 2'($urandom_range(0, 3));
         x  = pick();
         y  = pick();
         hw = ($urandom_range(0, 3) == 0);
         lw = ($urandom_range(0, 3) == 0);
         wait_free();
         repeat ($urandom_range(0, 2)) tick();
         issue(o, x, y, hw, lw, $urandom, 1'b0, '0, '0);
      end

      // reset 15 cycles into a MULT aborts it without a done pulse
      wait_free();
      tick();
      k0 = cyc;
      issue(2'b01, 32'h1234_5678, 32'h4000_0001, 1'b0, 1'b0, '0, 1'b0, '0, '0);
      while (cyc < k0 + 15) tick();
      reset = 1'b1;
      sb.delete();
      pend_v = 1'b0;
      m_hi = '0;
      m_lo = '0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      tick(); tick();
      reset = 1'b0;
      free_at = cyc;
      repeat (40) tick();

      // recovery after reset
      issue(2'b10, $urandom, 32'($urandom_range(1, 1000)), 1'b0, 1'b0, '0, 1'b0, '0, '0);
      wait_free();
      repeat (3) tick();

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
